ga_addsub_pipe: RTL and testbench



---
 rtl/ga_arith_pkg.sv | 31 +++
 rtl/ga_addsub_seg.sv | 31 +++
 rtl/ga_addsub_pipe.sv | 164 ++++++++++++++++
 tb/tb_ga_addsub_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ga_arith_pkg.sv
// rtl/ga_arith_pkg.sv - saturation modes and limit helpers for the GA arithmetic datapath
package ga_arith_pkg;

    typedef enum logic [1:0] {
        SAT_NONE     = 2'd0,
        SAT_UNSIGNED = 2'd1,
        SAT_SIGNED   = 2'd2
    } sat_mode_t;

    localparam int SAT_MAX_W = 64;

    // Limits are returned zero-extended to SAT_MAX_W; callers keep the low width bits.
    function automatic logic [SAT_MAX_W-1:0] sat_max(input sat_mode_t mode, input int width);
        logic [SAT_MAX_W-1:0] one;
        one = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
        if (mode == SAT_SIGNED) begin
            return (one << (width - 1)) - one;
        end
        return (one << width) - one;
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_min(input sat_mode_t mode, input int width);
        logic [SAT_MAX_W-1:0] one;
        one = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
        if (mode == SAT_SIGNED) begin
            return one << (width - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/ga_addsub_seg.sv
// rtl/ga_addsub_seg.sv - one carry-chain segment with a registered carry-out
module ga_addsub_seg #(
    parameter int SEG = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           cin_i,
    output logic [SEG-1:0] sum_o,
    output logic           cout_o,
    output logic           carry_o
);
    logic [SEG:0] full;
    logic         carry_q;

    assign full    = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};
    assign sum_o   = full[SEG-1:0];
    assign cout_o  = full[SEG];
    assign carry_o = carry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (load_i) begin
            carry_q <= full[SEG];
        end
    end

endmodule

// File: rtl/ga_addsub_pipe.sv
// rtl/ga_addsub_pipe.sv - pipelined add/sub with split carry chain, overflow flags and saturation
module ga_addsub_pipe
    import ga_arith_pkg::*;
#(
    parameter int        WIDTH    = 16,
    parameter int        STAGES   = 2,
    parameter sat_mode_t SAT_MODE = SAT_NONE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             sub,
    output logic             vail,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             C_out,
    output logic             ovf
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam logic [SAT_MAX_W-1:0] MAX_FULL = sat_max(SAT_MODE, WIDTH);
    localparam logic [SAT_MAX_W-1:0] MIN_FULL = sat_min(SAT_MODE, WIDTH);
    localparam logic [WIDTH-1:0]     RES_MAX  = MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     RES_MIN  = MIN_FULL[WIDTH-1:0];

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0 || WIDTH > SAT_MAX_W) begin : g_bad_cfg
        $error("ga_addsub_pipe: WIDTH must be a multiple of STAGES (1..WIDTH)");
    end

    logic             advance;
    logic             vail_q;
    logic             ovf_q;
    logic             last_carry;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] bx;

    // Global stall: every stage moves together or holds together.
    assign advance  = !vail_q || out_ready;
    assign in_ready = advance;
    assign bx       = sub ? ~B : B;
    assign vail     = vail_q;
    assign Result   = result_q;
    assign ovf      = ovf_q;
    assign C_out    = last_carry;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // HI: operand bits not yet summed; LO: result bits already produced upstream.
        localparam int HI = WIDTH - k * SEG;
        localparam int LO = k * SEG;

        logic [HI-1:0]     a_k;
        logic [HI-1:0]     bx_k;
        logic [LO+SEG-1:0] sum_k;
        logic [SEG-1:0]    seg_sum;
        logic              cin_k;
        logic              v_k;
        logic              sub_k;
        logic              seg_cout;
        logic              carry_k;
        logic              load_k;

        if (k == 0) begin : g_src
            assign a_k   = A;
            assign bx_k  = bx;
            assign cin_k = C_in;
            assign v_k   = en;
            assign sub_k = sub;
            assign sum_k = seg_sum;
        end else begin : g_src
            assign a_k   = g_stage[k-1].g_mid.a_q;
            assign bx_k  = g_stage[k-1].g_mid.bx_q;
            assign cin_k = g_stage[k-1].carry_k;
            assign v_k   = g_stage[k-1].g_mid.v_q;
            assign sub_k = g_stage[k-1].g_mid.sub_q;
            assign sum_k = {seg_sum, g_stage[k-1].g_mid.sum_q};
        end

        // The final carry doubles as C_out, so it only updates with a valid op.
        assign load_k = (k < LAST) ? advance : (advance && v_k);

        ga_addsub_seg #(
            .SEG(SEG)
        ) u_seg (
            .clk    (clk),
            .rst    (rst),
            .load_i (load_k),
            .a_i    (a_k[SEG-1:0]),
            .b_i    (bx_k[SEG-1:0]),
            .cin_i  (cin_k),
            .sum_o  (seg_sum),
            .cout_o (seg_cout),
            .carry_o(carry_k)
        );

        if (k < LAST) begin : g_mid
            logic [HI-SEG-1:0] a_q;
            logic [HI-SEG-1:0] bx_q;
            logic [LO+SEG-1:0] sum_q;
            logic              v_q;
            logic              sub_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q   <= '0;
                    bx_q  <= '0;
                    sum_q <= '0;
                    v_q   <= 1'b0;
                    sub_q <= 1'b0;
                end else if (advance) begin
                    a_q   <= a_k[HI-1:SEG];
                    bx_q  <= bx_k[HI-1:SEG];
                    sum_q <= sum_k;
                    v_q   <= v_k;
                    sub_q <= sub_k;
                end
            end
        end else begin : g_last
            logic             ovf_d;
            logic [WIDTH-1:0] result_d;

            assign ovf_d = (a_k[SEG-1] == bx_k[SEG-1]) && (sum_k[WIDTH-1] != a_k[SEG-1]);

            always_comb begin
                result_d = sum_k;
                case (SAT_MODE)
                    SAT_UNSIGNED: begin
                        if (!sub_k && seg_cout) begin
                            result_d = RES_MAX;
                        end else if (sub_k && !seg_cout) begin
                            result_d = RES_MIN;
                        end
                    end
                    SAT_SIGNED: begin
                        if (ovf_d) begin
                            result_d = a_k[SEG-1] ? RES_MIN : RES_MAX;
                        end
                    end
                    default: ;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vail_q   <= 1'b0;
                    result_q <= '0;
                    ovf_q    <= 1'b0;
                end else if (advance) begin
                    vail_q <= v_k;
                    if (v_k) begin
                        result_q <= result_d;
                        ovf_q    <= ovf_d;
                    end
                end
            end

            assign last_carry = carry_k;
        end
    end

endmodule

// File: tb/tb_ga_addsub_pipe.sv
// tb/tb_ga_addsub_pipe.sv - directed vector and corner-case bench for ga_addsub_pipe
module tb_ga_addsub_pipe;
    import ga_arith_pkg::*;

    localparam int        NDUT        = 5;
    localparam int        STG  [NDUT] = '{2, 2, 2, 1, 4};
    localparam sat_mode_t MODE [NDUT] = '{SAT_NONE, SAT_UNSIGNED, SAT_SIGNED, SAT_NONE, SAT_NONE};

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [15:0] r_none;
        logic [15:0] r_uns;
        logic [15:0] r_sgn;
        logic        co;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        out_ready;
    logic        C_in;
    logic        sub;
    logic [15:0] A;
    logic [15:0] B;

    logic        rdy_w  [NDUT];
    logic        vail_w [NDUT];
    logic        cout_w [NDUT];
    logic        ovf_w  [NDUT];
    logic [15:0] res_w  [NDUT];

    int          checks = 0;
    int          errors = 0;
    int          lat     [NDUT];
    logic [15:0] cap_res [NDUT];
    logic        cap_co  [NDUT];
    logic        cap_ov  [NDUT];
    vec_t        vecs    [10];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NDUT; i++) begin : g_dut
        ga_addsub_pipe #(
            .WIDTH   (16),
            .STAGES  (STG[i]),
            .SAT_MODE(MODE[i])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .in_ready (rdy_w[i]),
            .A        (A),
            .B        (B),
            .C_in     (C_in),
            .sub      (sub),
            .vail     (vail_w[i]),
            .out_ready(out_ready),
            .Result   (res_w[i]),
            .C_out    (cout_w[i]),
            .ovf      (ovf_w[i])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
        @(negedge clk);
        en = 1'b1; A = a; B = b; C_in = ci; sub = sb; out_ready = 1'b1;
        for (int d = 0; d < NDUT; d++) lat[d] = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) en = 1'b0;
            for (int d = 0; d < NDUT; d++) begin
                if (vail_w[d] && lat[d] == 0) begin
                    lat[d]     = n;
                    cap_res[d] = res_w[d];
                    cap_co[d]  = cout_w[d];
                    cap_ov[d]  = ovf_w[d];
                end
            end
        end
    endtask

    logic [15:0] bp_a   [4] = '{16'h1011, 16'h2022, 16'h3033, 16'h4044};
    logic [15:0] bp_exp [4] = '{16'h1112, 16'h2123, 16'h3134, 16'h4145};

    initial begin
        int          sent, got, stall_left, extra;
        logic        seen;
        logic [15:0] exp_r;

        //           a         b         ci    sb    none      uns       sgn       co    ov
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 16'h2233, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 16'h0000, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
        vecs[6] = '{16'h00FF, 16'hFF00, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
        vecs[8] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 16'h0002, 16'h0002, 1'b1, 1'b0};
        vecs[9] = '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000E, 16'h000E, 16'h000E, 1'b1, 1'b0};

        rst = 1'b1; en = 1'b0; out_ready = 1'b0; C_in = 1'b0; sub = 1'b0; A = '0; B = '0;
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("reset d%0d vail", d), 32'(vail_w[d]), 32'd0);
            chk($sformatf("reset d%0d result", d), 32'(res_w[d]), 32'd0);
            chk($sformatf("reset d%0d cout", d), 32'(cout_w[d]), 32'd0);
            chk($sformatf("reset d%0d ovf", d), 32'(ovf_w[d]), 32'd0);
            chk($sformatf("reset d%0d in_ready", d), 32'(rdy_w[d]), 32'd1);
        end
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_one(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb);
            for (int d = 0; d < NDUT; d++) begin
                exp_r = (d == 1) ? vecs[i].r_uns : (d == 2) ? vecs[i].r_sgn : vecs[i].r_none;
                chk($sformatf("v%0d d%0d latency", i, d), 32'(lat[d]), 32'(STG[d]));
                chk($sformatf("v%0d d%0d result", i, d), 32'(cap_res[d]), 32'(exp_r));
                chk($sformatf("v%0d d%0d cout", i, d), 32'(cap_co[d]), 32'(vecs[i].co));
                chk($sformatf("v%0d d%0d ovf", i, d), 32'(cap_ov[d]), 32'(vecs[i].ov));
            end
        end

        // Backpressure: four back-to-back ops, 3-cycle stall once the first result shows.
        sent = 0; got = 0; seen = 1'b0; stall_left = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            if (vail_w[0] && !seen) begin
                seen = 1'b1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            en = (sent < 4);
            if (sent < 4) A = bp_a[sent];
            B = 16'h0101; C_in = 1'b0; sub = 1'b0;
            #1;
            if (stall_left > 0) begin
                chk($sformatf("stall%0d in_ready", stall_left), 32'(rdy_w[0]), 32'd0);
                chk($sformatf("stall%0d vail", stall_left), 32'(vail_w[0]), 32'd1);
                chk($sformatf("stall%0d hold", stall_left), 32'(res_w[0]), 32'(bp_exp[0]));
                stall_left--;
            end
            if (vail_w[0] && out_ready) begin
                chk($sformatf("bp out%0d", got), 32'(res_w[0]), 32'(bp_exp[got]));
                got++;
            end
            if (en && rdy_w[0]) sent++;
        end
        en = 1'b0;
        chk("bp delivered", 32'(got), 32'd4);
        extra = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (vail_w[0]) extra++;
        end
        chk("bp no duplicates", 32'(extra), 32'd0);

        // Reset with ops in flight in every pipeline depth.
        @(negedge clk);
        en = 1'b1; A = 16'h0101; B = 16'h0101; C_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        A = 16'h0202;
        @(negedge clk);
        A = 16'h0303;
        @(negedge clk);
        en = 1'b0;
        #1;
        chk("pre-rst s1 vail", 32'(vail_w[3]), 32'd1);
        chk("pre-rst s1 result", 32'(res_w[3]), 32'h0404);
        chk("pre-rst s2 vail", 32'(vail_w[0]), 32'd1);
        chk("pre-rst s2 result", 32'(res_w[0]), 32'h0303);
        #1;
        rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("async rst d%0d vail", d), 32'(vail_w[d]), 32'd0);
            chk($sformatf("async rst d%0d result", d), 32'(res_w[d]), 32'd0);
            chk($sformatf("async rst d%0d in_ready", d), 32'(rdy_w[d]), 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        run_one(16'h4321, 16'h1111, 1'b0, 1'b0);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("post-rst d%0d latency", d), 32'(lat[d]), 32'(STG[d]));
            chk($sformatf("post-rst d%0d result", d), 32'(cap_res[d]), 32'h5432);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
